// File: rtl/bp_noc_link_pipe.sv
// Bidirectional multi-channel NoC link pipeline. Each channel and direction is a chain of
// two-entry FIFO stages with registered ready, followed by a delivered-flit counter.
module bp_noc_link_pipe #(
  parameter int unsigned width_p        = 64,
  parameter int unsigned num_channels_p = 5,
  parameter int unsigned depth_p        = 2,
  parameter int unsigned count_width_p  = 32
) (
  input  logic                                           clk_i,
  input  logic                                           reset_n_i,
  input  logic [num_channels_p-1:0][width_p+1:0]         side_A_links_i,
  output logic [num_channels_p-1:0][width_p+1:0]         side_A_links_o,
  input  logic [num_channels_p-1:0][width_p+1:0]         side_B_links_i,
  output logic [num_channels_p-1:0][width_p+1:0]         side_B_links_o,
  input  logic                                           clr_cnt_i,
  output logic [num_channels_p-1:0][count_width_p-1:0]   a2b_cnt_o,
  output logic [num_channels_p-1:0][count_width_p-1:0]   b2a_cnt_o,
  output logic                                           idle_o
);

  localparam int unsigned LinkWidth = width_p + 2;
  localparam int unsigned NumStages = (depth_p == 0) ? 1 : depth_p;

  logic [num_channels_p-1:0][1:0][NumStages-1:0] stage_empty;

  for (genvar c = 0; c < num_channels_p; c++) begin : g_chan
    // Direction 0 is A-in to B-out, direction 1 is B-in to A-out.
    logic [1:0]                     in_v, in_ready, out_v, out_ready;
    logic [1:0][width_p-1:0]        in_data, out_data;
    logic [1:0][count_width_p-1:0]  dir_cnt;

    assign in_v[0]      = side_A_links_i[c][LinkWidth-1];
    assign in_data[0]   = side_A_links_i[c][width_p:1];
    assign out_ready[1] = side_A_links_i[c][0];
    assign in_v[1]      = side_B_links_i[c][LinkWidth-1];
    assign in_data[1]   = side_B_links_i[c][width_p:1];
    assign out_ready[0] = side_B_links_i[c][0];

    // The ready we return on a side belongs to the direction entering from that side.
    assign side_B_links_o[c] = {out_v[0], out_data[0], in_ready[1]};
    assign side_A_links_o[c] = {out_v[1], out_data[1], in_ready[0]};

    assign a2b_cnt_o[c] = dir_cnt[0];
    assign b2a_cnt_o[c] = dir_cnt[1];

    for (genvar d = 0; d < 2; d++) begin : g_dir
      logic [count_width_p-1:0] flit_cnt_q;

      if (depth_p == 0) begin : g_pass
        assign out_v[d]          = in_v[d] & reset_n_i;
        assign out_data[d]       = in_data[d];
        assign in_ready[d]       = out_ready[d] & reset_n_i;
        assign stage_empty[c][d] = '1;
      end else begin : g_pipe
        logic [depth_p:0]              v_s, ready_s;
        logic [depth_p:0][width_p-1:0] data_s;

        assign v_s[0]           = in_v[d];
        assign data_s[0]        = in_data[d];
        assign ready_s[depth_p] = out_ready[d];
        assign in_ready[d]      = ready_s[0];
        assign out_v[d]         = v_s[depth_p];
        assign out_data[d]      = data_s[depth_p];

        for (genvar s = 0; s < depth_p; s++) begin : g_stage
          logic [width_p-1:0] mem_q [2];
          logic [1:0]         occ_q, occ_d;
          logic               rptr_q, ready_q, enq, deq, wptr;

          assign enq  = v_s[s] & ready_q;
          assign deq  = v_s[s+1] & ready_s[s+1];
          assign wptr = rptr_q ^ occ_q[0];

          always_comb begin
            occ_d = occ_q;
            if (enq && !deq) begin
              occ_d = occ_q + 2'd1;
            end else if (!enq && deq) begin
              occ_d = occ_q - 2'd1;
            end
          end

          // Ready is a flop of next-cycle not-full, so no ready path crosses a stage.
          always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
              occ_q   <= 2'd0;
              rptr_q  <= 1'b0;
              ready_q <= 1'b0;
            end else begin
              occ_q   <= occ_d;
              ready_q <= (occ_d != 2'd2);
              if (deq) begin
                rptr_q <= ~rptr_q;
              end
            end
          end

          always_ff @(posedge clk_i) begin
            if (enq) begin
              mem_q[wptr] <= data_s[s];
            end
          end

          assign ready_s[s]           = ready_q;
          assign v_s[s+1]             = (occ_q != 2'd0);
          assign data_s[s+1]          = mem_q[rptr_q];
          assign stage_empty[c][d][s] = (occ_q == 2'd0);
        end
      end

      always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
          flit_cnt_q <= '0;
        end else if (clr_cnt_i) begin
          flit_cnt_q <= '0;
        end else if (out_v[d] && out_ready[d]) begin
          flit_cnt_q <= flit_cnt_q + count_width_p'(1);
        end
      end

      assign dir_cnt[d] = flit_cnt_q;
    end
  end

  assign idle_o = &stage_empty;

endmodule

// File: tb/tb_bp_noc_link_pipe.sv
// Self-checking bench for bp_noc_link_pipe: directed latency/fill/reset cases plus a
// randomized all-channel stream checked against per-stream FIFO scoreboards.
module tb_bp_noc_link_pipe;

  localparam int W     = 64;
  localparam int NC    = 5;
  localparam int LW    = W + 2;
  localparam int CW    = 32;
  localparam int W0    = 16;
  localparam int LW0   = W0 + 2;
  localparam int NFLIT = 10000;

  logic clk, rst_n;

  // Main instance: depth 2, 32-bit counters.
  logic                   clr, idle;
  logic [NC-1:0][LW-1:0]  a_in, a_out, b_in, b_out;
  logic [NC-1:0][CW-1:0]  a2b_cnt, b2a_cnt;

  // Narrow-counter instance.
  logic                   clr4, idle4;
  logic [NC-1:0][LW-1:0]  a_in4, a_out4, b_in4, b_out4;
  logic [NC-1:0][3:0]     a2b4, b2a4;

  // Zero-depth instance.
  logic                   clr0, idle0;
  logic [NC-1:0][LW0-1:0] a_in0, a_out0, b_in0, b_out0;
  logic [NC-1:0][CW-1:0]  a2b0, b2a0;

  bp_noc_link_pipe #(.width_p(W), .num_channels_p(NC), .depth_p(2), .count_width_p(CW)) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .side_A_links_i(a_in), .side_A_links_o(a_out),
    .side_B_links_i(b_in), .side_B_links_o(b_out),
    .clr_cnt_i(clr), .a2b_cnt_o(a2b_cnt), .b2a_cnt_o(b2a_cnt), .idle_o(idle)
  );

  bp_noc_link_pipe #(.width_p(W), .num_channels_p(NC), .depth_p(2), .count_width_p(4)) dut_c4 (
    .clk_i(clk), .reset_n_i(rst_n),
    .side_A_links_i(a_in4), .side_A_links_o(a_out4),
    .side_B_links_i(b_in4), .side_B_links_o(b_out4),
    .clr_cnt_i(clr4), .a2b_cnt_o(a2b4), .b2a_cnt_o(b2a4), .idle_o(idle4)
  );

  bp_noc_link_pipe #(.width_p(W0), .num_channels_p(NC), .depth_p(0), .count_width_p(CW)) dut_d0 (
    .clk_i(clk), .reset_n_i(rst_n),
    .side_A_links_i(a_in0), .side_A_links_o(a_out0),
    .side_B_links_i(b_in0), .side_B_links_o(b_out0),
    .clr_cnt_i(clr0), .a2b_cnt_o(a2b0), .b2a_cnt_o(b2a0), .idle_o(idle0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Stream view of the main instance: d=0 is A->B, d=1 is B->A.
  function automatic logic in_v(input int c, input int d);
    return (d == 0) ? a_in[c][LW-1] : b_in[c][LW-1];
  endfunction
  function automatic logic [W-1:0] in_data(input int c, input int d);
    return (d == 0) ? a_in[c][LW-2:1] : b_in[c][LW-2:1];
  endfunction
  function automatic logic in_rdy(input int c, input int d);
    return (d == 0) ? a_out[c][0] : b_out[c][0];
  endfunction
  function automatic logic out_v(input int c, input int d);
    return (d == 0) ? b_out[c][LW-1] : a_out[c][LW-1];
  endfunction
  function automatic logic [W-1:0] out_data(input int c, input int d);
    return (d == 0) ? b_out[c][LW-2:1] : a_out[c][LW-2:1];
  endfunction
  function automatic logic out_rdy(input int c, input int d);
    return (d == 0) ? b_in[c][0] : a_in[c][0];
  endfunction

  task automatic drive_flit(input int c, input int d, input logic v, input logic [W-1:0] dat);
    if (d == 0) a_in[c][LW-1:1] = {v, dat};
    else        b_in[c][LW-1:1] = {v, dat};
  endtask

  task automatic drive_rdy(input int c, input int d, input logic r);
    if (d == 0) b_in[c][0] = r;
    else        a_in[c][0] = r;
  endtask

  task automatic drive_idle_inputs();
    for (int c = 0; c < NC; c++) begin
      a_in[c] = '0; a_in[c][0] = 1'b1;
      b_in[c] = '0; b_in[c][0] = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] sb [NC][2][$];
  int          sent_n [NC][2];
  int          rcvd_n [NC][2];
  bit          pend   [NC][2];
  int          hs_a2b [NC];
  int          hs_b2a [NC];

  initial begin
    #800000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  sent, cyc, guard;
    bit  done, any_v;

    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    clr = 1'b0; clr4 = 1'b0; clr0 = 1'b0;
    drive_idle_inputs();
    for (int c = 0; c < NC; c++) begin
      a_in4[c] = '0; a_in4[c][0] = 1'b1;
      b_in4[c] = '0; b_in4[c][0] = 1'b1;
      a_in0[c] = '0;
      b_in0[c] = '0;
    end

    // Reset state.
    #7;
    for (int c = 0; c < NC; c++) begin
      check_eq("rst_b_v", 64'(b_out[c][LW-1]), 64'd0);
      check_eq("rst_a_v", 64'(a_out[c][LW-1]), 64'd0);
      check_eq("rst_a_rdy", 64'(a_out[c][0]), 64'd0);
      check_eq("rst_b_rdy", 64'(b_out[c][0]), 64'd0);
      check_eq("rst_a2b", 64'(a2b_cnt[c]), 64'd0);
      check_eq("rst_b2a", 64'(b2a_cnt[c]), 64'd0);
    end
    check_eq("rst_idle", 64'(idle), 64'd1);
    #5 rst_n = 1'b1;
    step();
    for (int c = 0; c < NC; c++) begin
      check_eq("post_rst_a_rdy", 64'(a_out[c][0]), 64'd1);
      check_eq("post_rst_b_rdy", 64'(b_out[c][0]), 64'd1);
    end

    // Single flit latency on ch0 A->B.
    drive_flit(0, 0, 1'b1, 64'hA5);
    @(negedge clk);
    check_eq("lat_cyc0_v", 64'(out_v(0, 0)), 64'd0);
    step();
    drive_flit(0, 0, 1'b0, '0);
    @(negedge clk);
    check_eq("lat_cyc1_v", 64'(out_v(0, 0)), 64'd0);
    step();
    @(negedge clk);
    check_eq("lat_cyc2_v", 64'(out_v(0, 0)), 64'd1);
    check_eq("lat_cyc2_data", out_data(0, 0), 64'hA5);
    step();
    check_eq("lat_a2b_cnt0", 64'(a2b_cnt[0]), 64'd1);
    check_eq("lat_b2a_cnt0", 64'(b2a_cnt[0]), 64'd0);

    // Backpressure on ch1: capacity is 2*depth = 4.
    drive_rdy(1, 0, 1'b0);
    sent = 0;
    for (int i = 0; i < 10; i++) begin
      drive_flit(1, 0, 1'b1, 64'h100 + 64'(sent));
      @(negedge clk);
      if (in_rdy(1, 0)) sent++;
      step();
    end
    drive_flit(1, 0, 1'b0, '0);
    check_eq("fill_accepts", 64'(sent), 64'd4);
    check_eq("full_ready", 64'(in_rdy(1, 0)), 64'd0);
    check_eq("full_idle", 64'(idle), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("held_v", 64'(out_v(1, 0)), 64'd1);
      check_eq("held_data", out_data(1, 0), 64'h100);
      step();
    end
    drive_rdy(1, 0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("drain_v", 64'(out_v(1, 0)), 64'd1);
      check_eq("drain_data", out_data(1, 0), 64'h100 + 64'(k));
      step();
    end
    @(negedge clk);
    check_eq("drain_empty_v", 64'(out_v(1, 0)), 64'd0);
    check_eq("drain_a2b_cnt1", 64'(a2b_cnt[1]), 64'd4);
    step();

    // Randomized stream on every channel and direction with ~50% stalls.
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int c = 0; c < NC; c++) begin
      check_eq("clr_a2b", 64'(a2b_cnt[c]), 64'd0);
      check_eq("clr_b2a", 64'(b2a_cnt[c]), 64'd0);
    end
    for (int c = 0; c < NC; c++) begin
      for (int d = 0; d < 2; d++) begin
        sent_n[c][d] = 0;
        rcvd_n[c][d] = 0;
        pend[c][d]   = 1'b0;
        sb[c][d].delete();
      end
    end
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 60000) begin
      for (int c = 0; c < NC; c++) begin
        for (int d = 0; d < 2; d++) begin
          if (!pend[c][d]) begin
            if (sent_n[c][d] < NFLIT && $urandom_range(1) == 1) begin
              drive_flit(c, d, 1'b1, {8'(c), 8'(d), 16'(sent_n[c][d]), 32'($urandom())});
              pend[c][d] = 1'b1;
            end else begin
              drive_flit(c, d, 1'b0, '0);
            end
          end
          drive_rdy(c, d, 1'($urandom_range(1)));
        end
      end
      @(negedge clk);
      done = 1'b1;
      for (int c = 0; c < NC; c++) begin
        for (int d = 0; d < 2; d++) begin
          if (out_v(c, d) && out_rdy(c, d)) begin
            check_eq("sb_nonempty", 64'(sb[c][d].size() != 0), 64'd1);
            if (sb[c][d].size() != 0) begin
              check_eq("stream_data", out_data(c, d), sb[c][d].pop_front());
            end
            rcvd_n[c][d]++;
          end
          if (in_v(c, d) && in_rdy(c, d)) begin
            sb[c][d].push_back(in_data(c, d));
            sent_n[c][d]++;
            pend[c][d] = 1'b0;
          end
          if (rcvd_n[c][d] < NFLIT) done = 1'b0;
        end
      end
      step();
      cyc++;
    end
    drive_idle_inputs();
    check_eq("stream_done", 64'(done), 64'd1);
    for (int c = 0; c < NC; c++) begin
      check_eq("stream_a2b_cnt", 64'(a2b_cnt[c]), 64'(NFLIT));
      check_eq("stream_b2a_cnt", 64'(b2a_cnt[c]), 64'(NFLIT));
    end
    @(negedge clk);
    check_eq("stream_idle_end", 64'(idle), 64'd1);
    step();

    // Asynchronous reset mid-stream.
    drive_rdy(2, 0, 1'b0);
    drive_flit(2, 0, 1'b1, 64'hDEAD);
    drive_flit(3, 1, 1'b1, 64'hBEEF);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int c = 0; c < NC; c++) begin
      check_eq("arst_b_v", 64'(b_out[c][LW-1]), 64'd0);
      check_eq("arst_a_v", 64'(a_out[c][LW-1]), 64'd0);
      check_eq("arst_a_rdy", 64'(a_out[c][0]), 64'd0);
      check_eq("arst_b_rdy", 64'(b_out[c][0]), 64'd0);
      check_eq("arst_a2b", 64'(a2b_cnt[c]), 64'd0);
      check_eq("arst_b2a", 64'(b2a_cnt[c]), 64'd0);
    end
    check_eq("arst_idle", 64'(idle), 64'd1);
    drive_idle_inputs();
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    step();
    check_eq("arst_rel_rdy2", 64'(a_out[2][0]), 64'd1);
    check_eq("arst_rel_rdy3", 64'(b_out[3][0]), 64'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      any_v = 1'b0;
      for (int c = 0; c < NC; c++) any_v |= a_out[c][LW-1] | b_out[c][LW-1];
      check_eq("no_stale_flit", 64'(any_v), 64'd0);
      step();
    end

    // 4-bit counter wrap and clear priority.
    sent  = 0;
    guard = 0;
    while (sent < 17 && guard < 100) begin
      a_in4[0][LW-1:1] = {1'b1, 64'(sent)};
      @(negedge clk);
      if (a_out4[0][0]) sent++;
      step();
      guard++;
    end
    a_in4[0][LW-1] = 1'b0;
    repeat (4) step();
    check_eq("c4_wrap", 64'(a2b4[0]), 64'(17 % 16));
    a_in4[0][LW-1] = 1'b1;
    repeat (3) step();
    clr4 = 1'b1;
    @(negedge clk);
    check_eq("c4_hs_at_clr", 64'(b_out4[0][LW-1] & b_in4[0][0]), 64'd1);
    step();
    clr4 = 1'b0;
    check_eq("c4_clr_prio", 64'(a2b4[0]), 64'd0);
    step();
    check_eq("c4_after_clr", 64'(a2b4[0]), 64'd1);
    a_in4[0][LW-1] = 1'b0;

    // Zero depth: each side's outputs mirror the other side's inputs in the same cycle.
    for (int c = 0; c < NC; c++) begin
      hs_a2b[c] = 0;
      hs_b2a[c] = 0;
      check_eq("d0_a2b_start", 64'(a2b0[c]), 64'd0);
    end
    for (int i = 0; i < 20; i++) begin
      step();
      for (int c = 0; c < NC; c++) begin
        a_in0[c] = LW0'($urandom());
        b_in0[c] = LW0'($urandom());
      end
      #1;
      for (int c = 0; c < NC; c++) begin
        check_eq("d0_b_out", 64'(b_out0[c]), 64'(a_in0[c]));
        check_eq("d0_a_out", 64'(a_out0[c]), 64'(b_in0[c]));
        if (a_in0[c][LW0-1] && b_in0[c][0]) hs_a2b[c]++;
        if (b_in0[c][LW0-1] && a_in0[c][0]) hs_b2a[c]++;
      end
      check_eq("d0_idle", 64'(idle0), 64'd1);
    end
    step();
    for (int c = 0; c < NC; c++) begin
      a_in0[c] = '0;
      b_in0[c] = '0;
    end
    #1;
    for (int c = 0; c < NC; c++) begin
      check_eq("d0_a2b_cnt", 64'(a2b0[c]), 64'(hs_a2b[c]));
      check_eq("d0_b2a_cnt", 64'(b2a0[c]), 64'(hs_b2a[c]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_noc_link_pipe.md
BP_NOC_LINK_PIPE -- requirements
Module: bp_noc_link_pipe

Interface
REQ-001 The block SHALL take parameter width_p, default 64: flit payload width in bits.
REQ-002 The block SHALL take parameter num_channels_p, default 5: number of independent link channels (req, cmd, data_cmd, resp, data_resp).
REQ-003 The block SHALL take parameter depth_p, default 2, range 0..8: number of pipeline stages per direction per channel.
REQ-004 The block SHALL take parameter count_width_p, default 32: width of each flit counter.
REQ-005 The block SHALL pack each link as {v, data[width_p-1:0], ready_and_rev}, link width 2+width_p, v at the MSB.
REQ-006 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-007 The block SHALL have port reset_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port side_A_links_i, input, [num_channels_p][2+width_p]: A-side links into the block.
REQ-009 The block SHALL have port side_A_links_o, output, [num_channels_p][2+width_p]: A-side links out of the block.
REQ-010 The block SHALL have port side_B_links_i, input, [num_channels_p][2+width_p]: B-side links into the block.
REQ-011 The block SHALL have port side_B_links_o, output, [num_channels_p][2+width_p]: B-side links out of the block.
REQ-012 The block SHALL have port clr_cnt_i, input, 1 bit: synchronous clear of all flit counters.
REQ-013 The block SHALL have port a2b_cnt_o, output, [num_channels_p][count_width_p]: flits delivered on side B, per channel.
REQ-014 The block SHALL have port b2a_cnt_o, output, [num_channels_p][count_width_p]: flits delivered on side A, per channel.
REQ-015 The block SHALL have port idle_o, output, 1 bit: high when every stage buffer in every channel and direction is empty.

Function
REQ-016 Each channel SHALL carry two independent directions: A-in to B-out, and B-in to A-out.
REQ-017 A flit SHALL transfer on any link only in a cycle where v=1 and the receiver's ready_and_rev=1.
REQ-018 Each stage SHALL be a two-entry FIFO whose ready output is registered as not-full, sustaining 1 flit/cycle with no combinational ready path between stages.
REQ-019 With depth_p>=1, latency from input handshake to output v SHALL be exactly depth_p cycles when downstream is ready.
REQ-020 With depth_p>=1, capacity SHALL be 2*depth_p flits per direction per channel.
REQ-021 With depth_p=0, each direction SHALL be a combinational passthrough of v, data and ready.
REQ-022 Flit order SHALL be preserved within each direction of each channel.
REQ-023 Channels and directions SHALL never block one another.
REQ-024 Full stage: input ready SHALL be 0; a held flit SHALL remain stable until accepted.
REQ-025 Stage with one entry, simultaneous enqueue and dequeue: occupancy SHALL stay 1 and the old flit SHALL leave first.
REQ-026 Empty stage: output v SHALL be 0, and data is don't-care.
REQ-027 a2b_cnt_o[c] SHALL increment on each side-B output handshake of channel c; b2a_cnt_o[c] likewise on the side-A output.
REQ-028 Counters SHALL wrap modulo 2^count_width_p.
REQ-029 clr_cnt_i=1 SHALL load all counters to 0 on the next edge, taking priority over a simultaneous increment.
REQ-030 idle_o SHALL be a combinational AND of all stage-empty flags; idle_o SHALL be 1 when depth_p=0.

Reset
REQ-031 On reset_n_i=0 the block SHALL immediately and asynchronously empty all FIFOs and zero all counters.
REQ-032 While reset_n_i=0, all output v and all output ready_and_rev SHALL be 0, and idle_o SHALL be 1.
REQ-033 Flits in flight when reset asserts SHALL be discarded.
REQ-034 After reset_n_i deasserts, input ready SHALL be 1 from the first rising edge, with depth_p>=1.

Verification
REQ-035 Bench: depth_p=2, B ready, single flit 0xA5 on ch0 A at cycle 0 -> B ch0 v=1 with 0xA5 at cycle 2; a2b_cnt_o[0]=1.
REQ-036 Bench: depth_p=2, B ready held 0, stream on ch1 -> A ready drops after exactly 4 accepts; on B ready=1, the 4 flits exit in order, one per cycle.
REQ-037 Bench: all 5 channels, both directions, random stall 50%, 10000 flits each -> scoreboard exact order match; counters = 10000 each; idle_o=1 at end.
REQ-038 Bench: count_width_p=4, 17 flits -> a2b_cnt_o=1; clr_cnt_i pulsed together with a handshake -> counter=0.
REQ-039 Bench: reset_n_i pulled low mid-stream between edges -> outputs v=0 and ready=0 immediately, counters=0, and no stale flit emerges after release.
REQ-040 Bench: depth_p=0 -> same-cycle passthrough of v, data and ready verified; idle_o constant 1.
